tmds_encoder_mc: RTL and testbench
==================================

# tmds_encoder_mc

Parametrised multi-channel TMDS encoder for the HDMI transmit path, encoding NCH lanes per pixel clock.
- Supports DVI video encoding with per-lane running disparity, control-period codes, HDMI TERC4 data-island symbols and video/data guard bands.
- Sits between the video timing/packet mux and the 10:1 serialisers.
- Two-stage pipeline with clock enable.

## Interface
- NCH, 3, number of TMDS lanes (≥1); lane k uses guard codes of lane k mod 3.
- CNT_W, 5, signed running-disparity counter width (≥5).
- clk  in  1  pixel clock
- Reset_n  in  1  reset; one clock; asynchronous, active-low
- en  in  1  pipeline advance; when 0, all registers hold
- mode  in  3  lane mode shared by all lanes: 0 CTRL, 1 VIDEO, 2 ISLAND, 3 VGUARD, 4 DGUARD; 5–7 treated as CTRL
- din  in  NCH*8  video bytes, lane k = din[8k+7:8k]
- ctrl  in  NCH*2  control bits {c1,c0} per lane
- aux  in  NCH*4  TERC4 nibbles per lane
- dout  out  NCH*10  encoded symbols, lane k = dout[10k+9:10k]
- dout_vld  out  1  high once two en cycles have elapsed since reset

## Operation
- Stage 1 (per lane):
  - Compute n1 = ones(din).
  - XNOR when n1>4, or n1==4 and din[0]==0.
  - q_m[0]=din[0]; q_m[i]=q_m[i-1] XOR/XNOR din[i]; q_m[8]=~xnor.
  - Register q_m, N1=ones(q_m[7:0]), mode, ctrl, aux.
- Stage 2, VIDEO (DVI 1.0 algorithm; N0=8-N1):
  - cnt==0 or N1==N0:
    - dout={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}.
    - cnt += q_m[8]?(N1-N0):(N0-N1).
  - (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - dout={1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (N0-N1).
  - else:
    - dout={0, q_m[8], q_m[7:0]}.
    - cnt += −2·~q_m[8] + (N1-N0).
  - All arithmetic is signed CNT_W. |cnt| never exceeds 10; this is asserted.
- CTRL: {c1,c0} 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- ISLAND: dout=TERC4(aux) from the package table (0x0→1010011100 … 0xA→0110011100, 0xE→0101100011, 0xF→1011000011; full HDMI 1.4 table).
- VGUARD: lane mod 3 = 0 or 2 → 1011001100; lane mod 3 = 1 → 0100110011.
- DGUARD: lane mod 3 = 0 → TERC4({2'b11, c1, c0}); lanes 1, 2 → 0100110011.
- Every non-VIDEO stage-2 cycle with en=1 clears cnt to 0.
- Lanes are independent and have identical logic. Only the guard selection depends on the lane index.

## Timing
- Latency: 2 en-qualified cycles from input to dout.
- Reset (async assert, sync deassert handled externally):
  - dout=0, dout_vld=0, all cnt=0, stage-1 registers=0 (mode CTRL).
- Reset mid-frame: outputs drop to 0 immediately and cnt restarts at 0.
- en=0: dout, dout_vld, cnt and stage-1 registers all hold. No cnt update occurs on stalled cycles.
- Mode changes take effect per cycle with no gap. VIDEO→non-VIDEO→VIDEO always restarts from cnt=0.

## Configuration
- TMDS_TERC4_EN defined:
  - ISLAND and DGUARD operate as specified.
  - aux is used.
- TMDS_TERC4_EN undefined:
  - ISLAND and DGUARD behave as CTRL.
  - aux is ignored.
  - No TERC4 table logic is synthesised.
  - Port list is unchanged.

## Structure
- Package tmds_pkg holds:
  - the mode enum (tmds_mode_t)
  - the four control codes
  - the 16-entry TERC4 table
  - the two guard-band codes
  - the CNT_W default
- Sub-module tmds_lane_enc contains one lane (both stages plus cnt), parametrised by CNT_W and LANE_IDX. It is instantiated NCH times in a generate loop.
- The top level holds only dout_vld and port slicing.

## Test plan
- Reset: Reset_n=0 while running → dout=0, dout_vld=0 at once; after release and 2 en cycles → dout_vld=1.
- CTRL: mode=0, ctrl=01 on all lanes → every lane dout=0010101011 two cycles later; ctrl=11 → 1010101011.
- VIDEO sequence: din=8'h00 for 3 cycles from cnt=0 → dout 0100000000, 1111111111, 0100000000; cnt −8, 2, −6.
- Disparity clear: VIDEO (cnt≠0), one CTRL cycle, VIDEO din=8'h00 → first symbol 0100000000 (cnt=0 path).
- TERC4/guards (macro defined):
  - ISLAND aux=4'hA → 0110011100.
  - VGUARD → lanes 1011001100 / 0100110011 / 1011001100.
  - DGUARD ctrl0=10 → lane0 0101100011.
  - With macro undefined, ISLAND ctrl=00 → 1101010100.
- Stall: en=0 for 3 cycles mid-VIDEO → dout and cnt frozen; on resume the sequence continues exactly as with no stall.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, lane mode encoding and helpers for the multi-lane encoder.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_ISLAND = 3'd2,
        MODE_VGUARD = 3'd3,
        MODE_DGUARD = 3'd4
    } tmds_mode_t;

    localparam int CNT_W_DEF = 5;

    // indexed by {c1,c0}
    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_TBL [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
    localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: transition-minimising stage, then symbol select with running disparity.
// TERC4 island / data-guard symbols exist only when TMDS_TERC4_EN is defined.
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LANE_IDX = 0
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       en_i,
    input  logic [2:0] mode_i,
    input  logic [7:0] din_i,
    input  logic [1:0] ctrl_i,
    input  logic [3:0] aux_i,
    output logic [9:0] dout_o
);

    localparam logic signed [CNT_W-1:0] ZERO    = '0;
    localparam logic signed [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] TEN     = CNT_W'(10);
    localparam logic signed [CNT_W-1:0] NEG_TEN = -TEN;

    logic [3:0] n1_in;
    logic       use_xnor;
    logic [8:0] qm_d, qm_q;
    logic [3:0] n1_d, n1_q;
    logic [2:0] mode_q;
    logic [1:0] ctrl_q;
    logic [9:0] dout_d, dout_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;
    logic [3:0] n0_u;
    logic signed [CNT_W-1:0] n1_s, n0_s;

    always_comb begin
        n1_in    = ones8(din_i);
        use_xnor = (n1_in > 4'd4) || (n1_in == 4'd4 && !din_i[0]);
        qm_d     = '0;
        qm_d[0]  = din_i[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din_i[i]) : (qm_d[i-1] ^ din_i[i]);
        qm_d[8]  = ~use_xnor;
        n1_d     = ones8(qm_d[7:0]);
    end

`ifdef TMDS_TERC4_EN
    logic [3:0] aux_q;
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)  aux_q <= '0;
        else if (en_i) aux_q <= aux_i;
    end
`else
    logic unused_aux;
    assign unused_aux = ^aux_i;
`endif

    always_comb begin
        n0_u   = 4'd8 - n1_q;
        n1_s   = $signed(CNT_W'(n1_q));
        n0_s   = $signed(CNT_W'(n0_u));
        dout_d = CTRL_CODE[ctrl_q];
        cnt_d  = ZERO;
        case (mode_q)
            MODE_VIDEO: begin
                if (cnt_q == ZERO || n1_q == n0_u) begin
                    dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = qm_q[8] ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
                end else if ((cnt_q > ZERO && n1_q > n0_u) || (cnt_q < ZERO && n0_u > n1_q)) begin
                    dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) + n0_s - n1_s;
                end else begin
                    dout_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d  = cnt_q - (qm_q[8] ? ZERO : TWO) + n1_s - n0_s;
                end
            end
            MODE_VGUARD: dout_d = (LANE_IDX % 3 == 1) ? GUARD_CODE_B : GUARD_CODE_A;
`ifdef TMDS_TERC4_EN
            MODE_ISLAND: dout_d = TERC4_TBL[aux_q];
            MODE_DGUARD: dout_d = (LANE_IDX % 3 == 0) ? TERC4_TBL[{2'b11, ctrl_q}] : GUARD_CODE_B;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            qm_q   <= '0;
            n1_q   <= '0;
            mode_q <= MODE_CTRL;
            ctrl_q <= '0;
            dout_q <= '0;
            cnt_q  <= ZERO;
        end else if (en_i) begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            mode_q <= mode_i;
            ctrl_q <= ctrl_i;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o = dout_q;

    // DC balance guarantees the running disparity stays within +/-10
    a_cnt_bound: assert property (@(posedge clk) disable iff (!Reset_n)
        (cnt_q >= NEG_TEN) && (cnt_q <= TEN));

endmodule

// File: rtl/tmds_encoder_mc.sv
// NCH-lane TMDS encoder top: lane instances plus the output-valid tracker.
// TERC4 island / data-guard support is enabled by defining TMDS_TERC4_EN.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [NCH*8-1:0]  din,
    input  logic [NCH*2-1:0]  ctrl,
    input  logic [NCH*4-1:0]  aux,
    output logic [NCH*10-1:0] dout,
    output logic              dout_vld
);

    logic [1:0] vld_d, vld_q;

    assign vld_d = {vld_q[0], 1'b1};

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) vld_q <= '0;
        else if (en)  vld_q <= vld_d;
    end

    assign dout_vld = vld_q[1];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        tmds_lane_enc #(
            .CNT_W   (CNT_W),
            .LANE_IDX(k)
        ) u_lane (
            .clk    (clk),
            .Reset_n(Reset_n),
            .en_i   (en),
            .mode_i (mode),
            .din_i  (din[8*k +: 8]),
            .ctrl_i (ctrl[2*k +: 2]),
            .aux_i  (aux[4*k +: 4]),
            .dout_o (dout[10*k +: 10])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Bench for tmds_encoder_mc: per-cycle reference model plus hand-computed symbol checks.
module tb_tmds_encoder_mc;

    localparam int NCH = 3;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              en;
    logic [2:0]        mode;
    logic [NCH*8-1:0]  din;
    logic [NCH*2-1:0]  ctrl;
    logic [NCH*4-1:0]  aux;
    logic [NCH*10-1:0] dout;
    logic              dout_vld;

    tmds_encoder_mc #(.NCH(NCH), .CNT_W(5)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .en      (en),
        .mode    (mode),
        .din     (din),
        .ctrl    (ctrl),
        .aux     (aux),
        .dout    (dout),
        .dout_vld(dout_vld)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] T4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // ---------------- reference model ----------------
    logic [2:0] m_mode;
    logic [7:0] m_din  [NCH];
    logic [1:0] m_ctrl [NCH];
    logic [3:0] m_aux  [NCH];
    int         m_cnt  [NCH];
    logic [9:0] m_dout [NCH];
    int         m_en_seen;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic void video_calc(input logic [7:0] d, input int c,
                                       output logic [9:0] sym, output int nc);
        int n1, q1, q0;
        logic x, q8;
        logic [7:0] qm;
        n1 = $countones(d);
        x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = ~x;
        q1 = $countones(qm);
        q0 = 8 - q1;
        if (c == 0 || q1 == q0) begin
            sym = {~q8, q8, q8 ? qm : ~qm};
            nc  = c + (q8 ? (q1 - q0) : (q0 - q1));
        end else if ((c > 0 && q1 > q0) || (c < 0 && q0 > q1)) begin
            sym = {1'b1, q8, ~qm};
            nc  = c + 2 * int'(q8) + q0 - q1;
        end else begin
            sym = {1'b0, q8, qm};
            nc  = c - 2 * int'(!q8) + q1 - q0;
        end
    endfunction

    function automatic logic [2:0] eff_mode(input logic [2:0] m);
`ifdef TMDS_TERC4_EN
        return (m > 3'd4) ? 3'd0 : m;
`else
        return (m == 3'd1 || m == 3'd3) ? m : 3'd0;
`endif
    endfunction

    function automatic logic [9:0] f_sym(input int k);
        logic [9:0] s;
        int nc;
        case (eff_mode(m_mode))
            3'd1: video_calc(m_din[k], m_cnt[k], s, nc);
            3'd2: s = T4[m_aux[k]];
            3'd3: s = (k % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
            3'd4: s = (k % 3 == 0) ? T4[{2'b11, m_ctrl[k]}] : 10'b0100110011;
            default: s = ctrl_sym(m_ctrl[k]);
        endcase
        return s;
    endfunction

    function automatic int f_cnt(input int k);
        logic [9:0] s;
        int nc;
        nc = 0;
        if (eff_mode(m_mode) == 3'd1) video_calc(m_din[k], m_cnt[k], s, nc);
        return nc;
    endfunction

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_mode    <= 3'd0;
            m_en_seen <= 0;
            for (int k = 0; k < NCH; k++) begin
                m_din[k]  <= '0;
                m_ctrl[k] <= '0;
                m_aux[k]  <= '0;
                m_cnt[k]  <= 0;
                m_dout[k] <= '0;
            end
        end else if (en) begin
            m_mode    <= mode;
            m_en_seen <= (m_en_seen < 2) ? m_en_seen + 1 : 2;
            for (int k = 0; k < NCH; k++) begin
                m_dout[k] <= f_sym(k);
                m_cnt[k]  <= f_cnt(k);
                m_din[k]  <= din[8*k +: 8];
                m_ctrl[k] <= ctrl[2*k +: 2];
                m_aux[k]  <= aux[4*k +: 4];
            end
        end
    end

    // ---------------- literal expectations ----------------
    logic             lit_on;
    logic [NCH-1:0]   lit_mask;
    logic [9:0]       lit_val [NCH];
    string            lit_name;
    logic             lit_vld_on;
    logic             lit_vld;
    string            lit_vname;

    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            total++;
            if (dout[10*k +: 10] !== m_dout[k]) begin
                bad++;
                $display("FAIL model_dout lane%0d t=%0t got=%b want=%b", k, $time, dout[10*k +: 10], m_dout[k]);
            end
            if (lit_on && lit_mask[k]) begin
                total++;
                if (dout[10*k +: 10] !== lit_val[k]) begin
                    bad++;
                    $display("FAIL %s lane%0d t=%0t got=%b want=%b", lit_name, k, $time, dout[10*k +: 10], lit_val[k]);
                end
            end
        end
        total++;
        if (dout_vld !== (m_en_seen >= 2)) begin
            bad++;
            $display("FAIL model_vld t=%0t got=%b want=%b", $time, dout_vld, (m_en_seen >= 2));
        end
        if (lit_vld_on) begin
            total++;
            if (dout_vld !== lit_vld) begin
                bad++;
                $display("FAIL %s t=%0t got=%b want=%b", lit_vname, $time, dout_vld, lit_vld);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_on     = 1'b0;
        lit_mask   = '0;
        lit_vld_on = 1'b0;
    endtask

    task automatic expect_all(input logic [9:0] v, input string nm);
        for (int k = 0; k < NCH; k++) lit_val[k] = v;
        lit_mask = '1;
        lit_name = nm;
        lit_on   = 1'b1;
    endtask

    task automatic expect_lanes(input logic [9:0] v0, input logic [9:0] v1, input logic [9:0] v2,
                                input string nm);
        for (int k = 0; k < NCH; k++) lit_val[k] = (k % 3 == 0) ? v0 : ((k % 3 == 1) ? v1 : v2);
        lit_mask = '1;
        lit_name = nm;
        lit_on   = 1'b1;
    endtask

    task automatic expect_vld(input logic v, input string nm);
        lit_vld    = v;
        lit_vname  = nm;
        lit_vld_on = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset_n = 1'b1; en = 1'b1; mode = 3'd0;
        din = '0; ctrl = '0; aux = '0;
        lit_on = 1'b0; lit_mask = '0; lit_vld_on = 1'b0; lit_vld = 1'b0;
        lit_name = ""; lit_vname = "";
        for (int k = 0; k < NCH; k++) lit_val[k] = '0;
        #2 Reset_n = 1'b0;

        tick(); tick();
        expect_all(10'd0, "reset_dout"); expect_vld(1'b0, "reset_vld");
        tick();
        Reset_n = 1'b1;
        tick();
        expect_vld(1'b0, "vld_after_1"); expect_all(10'b1101010100, "first_ctrl00");
        tick();
        expect_vld(1'b1, "vld_after_2");

        // control codes
        mode = 3'd0; ctrl = {NCH{2'b01}};
        tick();
        ctrl = {NCH{2'b11}};
        tick(); expect_all(10'b0010101011, "ctrl01");
        tick(); expect_all(10'b1010101011, "ctrl11");
        tick();

        // video 00 x3, one control cycle, video 00 again
        mode = 3'd1; din = '0;
        tick();
        tick(); expect_all(10'b0100000000, "vid00_a");
        tick(); expect_all(10'b1111111111, "vid00_b");
        mode = 3'd0;
        tick(); expect_all(10'b0100000000, "vid00_c");
        mode = 3'd1;
        tick(); expect_all(10'b1010101011, "vid_gap_ctrl");
        mode = 3'd0;
        tick(); expect_all(10'b0100000000, "disp_clear");
        tick();

        // stall in the middle of a video run
        mode = 3'd1; din = '0;
        tick();
        tick(); expect_all(10'b0100000000, "stall_pre");
        en = 1'b0;
        tick(); expect_all(10'b0100000000, "stall_hold1");
        tick(); expect_all(10'b0100000000, "stall_hold2");
        tick(); expect_all(10'b0100000000, "stall_hold3");
        en = 1'b1;
        tick(); expect_all(10'b1111111111, "stall_resume");
        mode = 3'd0;
        tick(); expect_all(10'b0100000000, "stall_seq3");
        tick();

`ifdef TMDS_TERC4_EN
        mode = 3'd2; aux = {NCH{4'hA}};
        tick();
        mode = 3'd3;
        tick(); expect_all(10'b0110011100, "island_A");
        mode = 3'd4; ctrl = '0; ctrl[1:0] = 2'b10;
        tick(); expect_lanes(10'b1011001100, 10'b0100110011, 10'b1011001100, "vguard");
        mode = 3'd0;
        tick(); expect_lanes(10'b0101100011, 10'b0100110011, 10'b0100110011, "dguard");
        tick();
`else
        mode = 3'd2; ctrl = '0; aux = {NCH{4'hA}};
        tick();
        mode = 3'd3;
        tick(); expect_all(10'b1101010100, "island_as_ctrl");
        mode = 3'd0;
        tick(); expect_lanes(10'b1011001100, 10'b0100110011, 10'b1011001100, "vguard");
        tick();
`endif

        // per-lane distinct video bytes, then reset mid-frame
        mode = 3'd1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NCH; k++) din[8*k +: 8] = 8'(8'h1F * (i + 1) + 8'(k * 37));
            tick();
        end
        Reset_n = 1'b0;
        expect_all(10'd0, "midrst_dout"); expect_vld(1'b0, "midrst_vld");
        tick();
        Reset_n = 1'b1;

        // random mixed traffic, model-checked every cycle
        for (int i = 0; i < 500; i++) begin
            en   = ($urandom_range(0, 4) != 0);
            mode = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
            for (int k = 0; k < NCH; k++) begin
                din[8*k +: 8]  = 8'($urandom);
                ctrl[2*k +: 2] = 2'($urandom);
                aux[4*k +: 4]  = 4'($urandom);
            end
            tick();
        end
        en = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
